// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rob_pkg
//  Description : Shared types and constants for the reorder buffer: the
//                per-entry record, the buffer state encoding and the default
//                widths used by the buffer and its neighbours.
//  Revision    : 1.0  initial release
// ============================================================================
// The physical register count normally comes from nand_cpu.svh. A fallback
// keeps this package self-contained when that header is not on the path.
`ifndef NUM_REG
`define NUM_REG 32
`endif

package rob_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
  localparam int ROB_VREG_W = 4;
  localparam int ROB_PREG_W = $clog2(`NUM_REG);

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  reg_write;
    logic [ROB_VREG_W-1:0] v_reg;
    logic [ROB_PREG_W-1:0] p_reg;
    logic [ROB_PREG_W-1:0] old_p_reg;
  } rob_entry_t;

  typedef enum logic [0:0] {
    NORMAL   = 1'b0,
    ROLLBACK = 1'b1
  } rob_state_t;

endpackage

`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular in-order tracking buffer. Dispatch allocates at the
//                tail, execution marks entries done by tag, the head retires
//                in order and checks its superseded physical register back in.
//                A branch flush walks back from the tail one entry per cycle,
//                checking squashed registers in and emitting translation-table
//                restore writes.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, n_rst                 clock, asynchronous active-low reset
//    alloc_valid/alloc_ready    dispatch handshake (ready is combinational)
//    alloc_reg_write/v_reg/p_reg/old_p_reg   fields of the new entry
//    alloc_tag                  tag given to the entry (current tail)
//    complete_valid/complete_tag   execution finished an entry
//    flush_valid/flush_tag      squash everything younger than flush_tag
//    reg_commit/commit_addr     free-list check-in strobe (registered)
//    retire_valid               head retired on the previous edge
//    rb_valid/rb_v_reg/rb_p_reg translation restore write (registered)
//    busy                       walk-back in progress
// ============================================================================
module reorder_buffer
  import rob_pkg::*;
#(
  // Entry fields use the package widths; keep these at their defaults.
  parameter int DEPTH  = ROB_DEPTH,
  parameter int PREG_W = ROB_PREG_W,
  parameter int VREG_W = ROB_VREG_W
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic                     alloc_reg_write,
  input  logic [VREG_W-1:0]        alloc_v_reg,
  input  logic [PREG_W-1:0]        alloc_p_reg,
  input  logic [PREG_W-1:0]        alloc_old_p_reg,
  output logic [$clog2(DEPTH)-1:0] alloc_tag,
  input  logic                     complete_valid,
  input  logic [$clog2(DEPTH)-1:0] complete_tag,
  input  logic                     flush_valid,
  input  logic [$clog2(DEPTH)-1:0] flush_tag,
  output logic                     reg_commit,
  output logic [PREG_W-1:0]        commit_addr,
  output logic                     retire_valid,
  output logic                     rb_valid,
  output logic [VREG_W-1:0]        rb_v_reg,
  output logic [PREG_W-1:0]        rb_p_reg,
  output logic                     busy
);

  localparam int TAG_W = $clog2(DEPTH);
  // One extra bit so that full and empty are distinct counts.
  localparam int CNT_W = TAG_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];

  rob_state_t         state_q, state_d;
  logic [TAG_W-1:0]   head_q, head_d;
  logic [TAG_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TAG_W-1:0]   flush_tag_q, flush_tag_d;

  logic               reg_commit_q, reg_commit_d;
  logic [PREG_W-1:0]  commit_addr_q, commit_addr_d;
  logic               retire_valid_q, retire_valid_d;
  logic               rb_valid_q, rb_valid_d;
  logic [VREG_W-1:0]  rb_v_reg_q, rb_v_reg_d;
  logic [PREG_W-1:0]  rb_p_reg_q, rb_p_reg_d;

  logic [TAG_W-1:0]   pop_idx;
  logic [TAG_W-1:0]   stop_idx;
  logic               alloc_fire;
  rob_entry_t         head_entry;
  rob_entry_t         pop_entry;

  // pop_idx is the youngest live entry (tail-1); the walk-back ends once the
  // entry just above the surviving flush target has been popped.
  assign pop_idx    = tail_q - TAG_W'(1);
  assign stop_idx   = flush_tag_q + TAG_W'(1);
  assign head_entry = entries_q[head_q];
  assign pop_entry  = entries_q[pop_idx];

  assign alloc_ready = (state_q == NORMAL) && (count_q < CNT_FULL) && !flush_valid;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_q;

  always_comb begin
    entries_d      = entries_q;
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    flush_tag_d    = flush_tag_q;
    reg_commit_d   = 1'b0;
    commit_addr_d  = '0;
    retire_valid_d = 1'b0;
    rb_valid_d     = 1'b0;
    rb_v_reg_d     = '0;
    rb_p_reg_d     = '0;

    // Completion is applied first so that a pop of the same entry below
    // overrides it; completions to empty slots are dropped.
    if (complete_valid && entries_q[complete_tag].valid) begin
      entries_d[complete_tag].done = 1'b1;
    end

    case (state_q)
      NORMAL: begin
        if (flush_valid) begin
          // A flush naming the youngest entry squashes nothing.
          if (flush_tag != pop_idx) begin
            state_d     = ROLLBACK;
            flush_tag_d = flush_tag;
          end
        end else if ((count_q != '0) && head_entry.valid && head_entry.done) begin
          entries_d[head_q] = '0;
          head_d            = head_q + TAG_W'(1);
          count_d           = count_d - CNT_W'(1);
          retire_valid_d    = 1'b1;
          if (head_entry.reg_write) begin
            reg_commit_d  = 1'b1;
            commit_addr_d = head_entry.old_p_reg;
          end
        end

        if (alloc_fire) begin
          entries_d[tail_q] = '{valid:     1'b1,
                                done:      1'b0,
                                reg_write: alloc_reg_write,
                                v_reg:     alloc_v_reg,
                                p_reg:     alloc_p_reg,
                                old_p_reg: alloc_old_p_reg};
          tail_d  = tail_q + TAG_W'(1);
          count_d = count_d + CNT_W'(1);
        end
      end

      ROLLBACK: begin
        // Youngest-first, so the last restore per register is the oldest
        // squashed mapping.
        entries_d[pop_idx] = '0;
        tail_d             = pop_idx;
        count_d            = count_q - CNT_W'(1);
        if (pop_entry.reg_write) begin
          reg_commit_d  = 1'b1;
          commit_addr_d = pop_entry.p_reg;
          rb_valid_d    = 1'b1;
          rb_v_reg_d    = pop_entry.v_reg;
          rb_p_reg_d    = pop_entry.old_p_reg;
        end
        if (pop_idx == stop_idx) begin
          state_d = NORMAL;
        end
      end

      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= NORMAL;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      flush_tag_q    <= '0;
      reg_commit_q   <= 1'b0;
      commit_addr_q  <= '0;
      retire_valid_q <= 1'b0;
      rb_valid_q     <= 1'b0;
      rb_v_reg_q     <= '0;
      rb_p_reg_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      flush_tag_q    <= flush_tag_d;
      reg_commit_q   <= reg_commit_d;
      commit_addr_q  <= commit_addr_d;
      retire_valid_q <= retire_valid_d;
      rb_valid_q     <= rb_valid_d;
      rb_v_reg_q     <= rb_v_reg_d;
      rb_p_reg_q     <= rb_p_reg_d;
      entries_q      <= entries_d;
    end
  end

  assign reg_commit   = reg_commit_q;
  assign commit_addr  = commit_addr_q;
  assign retire_valid = retire_valid_q;
  assign rb_valid     = rb_valid_q;
  assign rb_v_reg     = rb_v_reg_q;
  assign rb_p_reg     = rb_p_reg_q;
  assign busy         = (state_q == ROLLBACK);

`ifndef SYNTHESIS
  a_no_flush_in_rollback : assert property (
    @(posedge clk) disable iff (!n_rst) (state_q == ROLLBACK) |-> !flush_valid);
  a_flush_tag_live : assert property (
    @(posedge clk) disable iff (!n_rst)
      (flush_valid && state_q == NORMAL) |-> entries_q[flush_tag].valid);
`endif

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reorder_buffer
//  Description : Self-checking bench for reorder_buffer. A queue-based model
//                tracks live entries oldest-first and predicts every output;
//                directed sequences pin the model with literal values, then a
//                randomized phase exercises alloc/complete/flush mixes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reorder_buffer;
  import rob_pkg::*;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int VREG_W = 4;
  localparam int PREG_W = ROB_PREG_W;
  localparam int NREG   = 1 << PREG_W;

  logic              clk;
  logic              n_rst;
  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_reg_write;
  logic [VREG_W-1:0] alloc_v_reg;
  logic [PREG_W-1:0] alloc_p_reg;
  logic [PREG_W-1:0] alloc_old_p_reg;
  logic [TAG_W-1:0]  alloc_tag;
  logic              complete_valid;
  logic [TAG_W-1:0]  complete_tag;
  logic              flush_valid;
  logic [TAG_W-1:0]  flush_tag;
  logic              reg_commit;
  logic [PREG_W-1:0] commit_addr;
  logic              retire_valid;
  logic              rb_valid;
  logic [VREG_W-1:0] rb_v_reg;
  logic [PREG_W-1:0] rb_p_reg;
  logic              busy;

  reorder_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .VREG_W(VREG_W)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_reg_write (alloc_reg_write),
    .alloc_v_reg     (alloc_v_reg),
    .alloc_p_reg     (alloc_p_reg),
    .alloc_old_p_reg (alloc_old_p_reg),
    .alloc_tag       (alloc_tag),
    .complete_valid  (complete_valid),
    .complete_tag    (complete_tag),
    .flush_valid     (flush_valid),
    .flush_tag       (flush_tag),
    .reg_commit      (reg_commit),
    .commit_addr     (commit_addr),
    .retire_valid    (retire_valid),
    .rb_valid        (rb_valid),
    .rb_v_reg        (rb_v_reg),
    .rb_p_reg        (rb_p_reg),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_retire = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int tag;
    bit rw;
    int v;
    int p;
    int old;
    bit done;
  } ment_t;

  ment_t rob[$];          // live entries, oldest first
  int    m_tail   = 0;
  bit    m_roll   = 0;
  int    m_ftag   = 0;
  bit    e_retire = 0;
  bit    e_commit = 0;
  int    e_caddr  = 0;
  bit    e_rb     = 0;
  int    e_rbv    = 0;
  int    e_rbp    = 0;

  function automatic bit m_ready();
    return !m_roll && (rob.size() < DEPTH) && !flush_valid;
  endfunction

  task automatic model_step();
    ment_t e;
    ment_t ne;
    bit    acc;
    acc      = alloc_valid && m_ready();
    e_retire = 0; e_commit = 0; e_caddr = 0;
    e_rb     = 0; e_rbv    = 0; e_rbp   = 0;
    if (!m_roll) begin
      if (flush_valid) begin
        if (int'(flush_tag) != (m_tail + DEPTH - 1) % DEPTH) begin
          m_roll = 1;
          m_ftag = int'(flush_tag);
        end
      end else if (rob.size() > 0 && rob[0].done) begin
        e = rob.pop_front();
        e_retire = 1;
        if (e.rw) begin
          e_commit = 1;
          e_caddr  = e.old;
        end
      end
    end else if (rob.size() > 0) begin
      e = rob.pop_back();
      m_tail = (m_tail + DEPTH - 1) % DEPTH;
      if (e.rw) begin
        e_commit = 1; e_caddr = e.p;
        e_rb = 1; e_rbv = e.v; e_rbp = e.old;
      end
      if (e.tag == (m_ftag + 1) % DEPTH) m_roll = 0;
    end
    if (complete_valid) begin
      foreach (rob[i]) if (rob[i].tag == int'(complete_tag)) rob[i].done = 1;
    end
    if (acc) begin
      ne.tag = m_tail; ne.rw = alloc_reg_write; ne.v = int'(alloc_v_reg);
      ne.p = int'(alloc_p_reg); ne.old = int'(alloc_old_p_reg); ne.done = 0;
      rob.push_back(ne);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rob.delete();
      m_tail = 0; m_roll = 0; m_ftag = 0;
      e_retire = 0; e_commit = 0; e_caddr = 0;
      e_rb = 0; e_rbv = 0; e_rbp = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    #1;
    chk("alloc_ready", alloc_ready, m_ready());
    chk("alloc_tag", alloc_tag, m_tail);
    chk("busy", busy, m_roll);
    chk("retire_valid", retire_valid, e_retire);
    chk("reg_commit", reg_commit, e_commit);
    if (e_commit) chk("commit_addr", commit_addr, e_caddr);
    chk("rb_valid", rb_valid, e_rb);
    if (e_rb) begin
      chk("rb_v_reg", rb_v_reg, e_rbv);
      chk("rb_p_reg", rb_p_reg, e_rbp);
    end
    if (retire_valid === 1'b1) n_retire++;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    alloc_valid = 0; alloc_reg_write = 0; alloc_v_reg = '0;
    alloc_p_reg = '0; alloc_old_p_reg = '0;
    complete_valid = 0; complete_tag = '0;
    flush_valid = 0; flush_tag = '0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic alloc(input bit rw, input int v, input int p, input int old);
    alloc_valid = 1; alloc_reg_write = rw;
    alloc_v_reg = VREG_W'(v); alloc_p_reg = PREG_W'(p); alloc_old_p_reg = PREG_W'(old);
  endtask

  task automatic complete(input int t);
    complete_valid = 1; complete_tag = TAG_W'(t);
  endtask

  task automatic do_reset();
    nxt(); n_rst = 0;
    nxt(); n_rst = 1;
  endtask

  int base;

  initial begin
    n_rst = 0;
    idle();
    repeat (2) @(negedge clk);
    n_rst = 1;
    #2;
    chk("rst_ready", alloc_ready, 1);
    chk("rst_commit", reg_commit, 0);
    chk("rst_retire", retire_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tag", alloc_tag, 0);

    // Fill: 16 back-to-back, 17th refused.
    for (int i = 0; i < DEPTH; i++) begin
      nxt(); alloc(1, i, i, (i + 3) % NREG);
      #2;
      chk("fill_tag", alloc_tag, i);
      chk("fill_ready", alloc_ready, 1);
    end
    nxt(); alloc(1, 0, 1, 1);
    #2;
    chk("full_ready", alloc_ready, 0);
    // Drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      nxt(); complete(i);
    end
    repeat (4) nxt();

    // Reset in the middle of traffic.
    nxt(); alloc(1, 2, 3, 4);
    nxt(); alloc(1, 5, 6, 7);
    nxt(); n_rst = 0;
    #2;
    chk("midrst_ready", alloc_ready, 1);
    chk("midrst_retire", retire_valid, 0);
    chk("midrst_busy", busy, 0);
    nxt(); n_rst = 1;
    #2;
    chk("midrst_tag", alloc_tag, 0);

    // Out-of-order completion, in-order retire.
    nxt(); alloc(1, 1, 8, 5);
    nxt(); alloc(1, 2, 9, 6);
    nxt(); alloc(1, 3, 10, 7);
    nxt(); complete(2);
    nxt(); complete(1);
    nxt(); complete(0);
    nxt(); #2 chk("ooo_wait", retire_valid, 0);
    nxt(); #2 chk("ooo_r0", retire_valid, 1); chk("ooo_c0", commit_addr, 5);
    nxt(); #2 chk("ooo_r1", retire_valid, 1); chk("ooo_c1", commit_addr, 6);
    nxt(); #2 chk("ooo_r2", retire_valid, 1); chk("ooo_c2", commit_addr, 7);
    nxt(); #2 chk("ooo_end", retire_valid, 0);

    // Flush rollback from tags 0..3 back to tag 1.
    do_reset();
    nxt(); alloc(1, 1, 20, 10);
    nxt(); alloc(1, 2, 21, 11);
    nxt(); alloc(1, 1, 22, 20);
    nxt(); alloc(0, 0, 0, 0);
    nxt(); flush_valid = 1; flush_tag = 1;
    nxt(); #2 chk("fl_busy0", busy, 1); chk("fl_rb0", rb_valid, 0);
    nxt(); #2 chk("fl_busy1", busy, 1); chk("fl_rb1", rb_valid, 0); chk("fl_rc1", reg_commit, 0);
    nxt(); #2
    chk("fl_busy2", busy, 0);
    chk("fl_rb2", rb_valid, 1);
    chk("fl_caddr", commit_addr, 22);
    chk("fl_rbv", rb_v_reg, 1);
    chk("fl_rbp", rb_p_reg, 20);
    chk("fl_tag", alloc_tag, 2);

    // Flush naming the youngest entry: nothing happens, retire resumes after.
    complete(0);
    nxt(); complete(1);
    nxt(); flush_valid = 1; flush_tag = 1;
    #2 chk("nf_r0", retire_valid, 1); chk("nf_c0", commit_addr, 10);
    nxt(); #2 chk("nf_busy", busy, 0); chk("nf_hold", retire_valid, 0);
    nxt(); #2 chk("nf_r1", retire_valid, 1); chk("nf_c1", commit_addr, 11);

    // Steady alloc + retire across the tag wrap.
    repeat (2) nxt();
    base = n_retire;
    for (int i = 0; i < 40; i++) begin
      nxt(); alloc(1, i % 16, i % NREG, (i + 7) % NREG);
      foreach (rob[k]) if (!rob[k].done) begin complete(rob[k].tag); break; end
    end
    for (int i = 0; i < 10; i++) begin
      nxt();
      foreach (rob[k]) if (!rob[k].done) begin complete(rob[k].tag); break; end
    end
    chk("wrap_retires", n_retire - base, 40);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      nxt();
      if ($urandom_range(0, 9) < 6)
        alloc($urandom_range(0, 3) != 0, $urandom_range(0, 15),
              $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1));
      if ($urandom_range(0, 1) == 1) begin
        if (rob.size() > 0 && $urandom_range(0, 3) != 0)
          complete(rob[$urandom_range(0, rob.size() - 1)].tag);
        else
          complete($urandom_range(0, DEPTH - 1));
      end
      if (!m_roll && rob.size() > 0 && $urandom_range(0, 24) == 0) begin
        flush_valid = 1;
        flush_tag = TAG_W'(rob[$urandom_range(0, rob.size() - 1)].tag);
      end
    end
    repeat (DEPTH + 4) nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
